// File: rtl/reg_file_pkg.sv
// Shared constants and FSM state type for the multi-port register file.
package reg_file_pkg;

  localparam int unsigned REGFILE_WIDTH = 32;
  localparam int unsigned REGFILE_DEPTH = 32;
  localparam int unsigned REGFILE_NREAD = 2;

  // Clear sweep after reset, then normal operation.
  typedef enum logic [0:0] {
    StClear = 1'b0,
    StRun   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: read mux, r0 masking, optional write-to-read bypass
// (enabled by the REGFILE_BYPASS_EN macro) and the output register.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = REGFILE_WIDTH,
  parameter int unsigned DEPTH = REGFILE_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_run,
  input  logic                            i_we,
  input  logic [$clog2(DEPTH)-1:0]        i_wn,
  input  logic [WIDTH-1:0]                i_wd,
  input  logic [$clog2(DEPTH)-1:0]        i_rn,
  input  logic [DEPTH-1:0][WIDTH-1:0]     i_mem,
  output logic [WIDTH-1:0]                o_rd
);

  logic [WIDTH-1:0] w_rd_d;
  logic [WIDTH-1:0] r_rd;

  // Select next read data; zero during the sweep and for register 0.
  always_comb begin
    w_rd_d = '0;
    if (i_run && (i_rn != '0)) begin
`ifdef REGFILE_BYPASS_EN
      // Write-before-read: a same-cycle write to this register wins.
      if (i_we && (i_wn == i_rn)) begin
        w_rd_d = i_wd;
      end else begin
        w_rd_d = i_mem[i_rn];
      end
`else
      w_rd_d = i_mem[i_rn];
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  // Write-side inputs only matter when bypass is built in.
  logic w_unused_wr;
  assign w_unused_wr = ^{i_we, i_wn, i_wd};
`endif

  // Output register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= '0;
    end else begin
      r_rd <= w_rd_d;
    end
  end

  assign o_rd = r_rd;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with registered reads and a
// post-reset clear sweep. Register 0 reads as zero. Define REGFILE_BYPASS_EN
// for same-cycle write-to-read forwarding (otherwise read-before-write).
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = REGFILE_WIDTH,
  parameter int unsigned DEPTH = REGFILE_DEPTH,
  parameter int unsigned NREAD = REGFILE_NREAD
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              reg_write,
  input  logic [$clog2(DEPTH)-1:0]          wn,
  input  logic [WIDTH-1:0]                  wd,
  input  logic [NREAD*$clog2(DEPTH)-1:0]    rn,
  output logic [NREAD*WIDTH-1:0]            rd,
  output logic                              ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  rf_state_e                   r_state;
  rf_state_e                   w_state_d;
  logic [AW-1:0]               r_ptr;
  logic [AW-1:0]               w_ptr_d;
  logic                        w_run;
  // Storage has no reset; the sweep clears it.
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;

  assign w_run = (r_state == StRun);
  assign ready = w_run;

  // FSM state and clear pointer; reset restarts the sweep at entry 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StClear;
      r_ptr   <= AW'(1);
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
    end
  end

  // Next-state: walk the pointer to the last entry, then enter RUN.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    case (r_state)
      StClear: begin
        w_ptr_d = r_ptr + 1'b1;
        if (r_ptr == LastIdx) begin
          w_state_d = StRun;
        end
      end
      StRun:   w_state_d = StRun;
      default: w_state_d = StClear;
    endcase
  end

  // Array write: sweep zeroes in CLEAR, user writes (except r0) in RUN.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_ptr] <= '0;
    end else if (reg_write && (wn != '0)) begin
      r_mem[wn] <= wd;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    reg_file_rd_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_rd_port (
      .clk   (clk),
      .rst_n (rst_n),
      .i_run (w_run),
      .i_we  (reg_write),
      .i_wn  (wn),
      .i_wd  (wd),
      .i_rn  (rn[gi*AW +: AW]),
      .i_mem (r_mem),
      .o_rd  (rd[gi*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the pipelined MIPS datapath, the successor of the fixed 32x32, two-read-port file. It provides configurable width, depth and read-port count, and registered read data with one-cycle latency. Register 0 is hardwired to zero. After reset, a sequential clear sweep zeroes the array, so the storage itself needs no reset and maps onto flop/latch arrays or memory macros. Optional same-cycle write-to-read forwarding removes the ID-stage hazard with WB.

## Interface
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers; power of two, at least 2; derived AW = $clog2(DEPTH)
- NREAD, 2, number of independent read ports, at least 1
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- reg_write  input  1  write enable
- wn  input  AW  write register number
- wd  input  WIDTH  write data
- rn  input  NREAD*AW  read register numbers; port i occupies bits [i*AW +: AW]
- rd  output  NREAD*WIDTH  registered read data; port i occupies bits [i*WIDTH +: WIDTH]
- ready  output  1  high once the clear sweep is complete

One clock; reset is asynchronous and active-low.

## Operation
- FSM has two states, CLEAR and RUN.
- **Reset (rst_n low), asynchronous:**
  - state becomes CLEAR, clear pointer becomes 1.
  - ready becomes 0 and all rd lanes become 0.
  - The array is not reset.
- **CLEAR state, each cycle:**
  - Write 0 to entry[ptr], then increment ptr.
  - After entry DEPTH-1 is written, state becomes RUN and ready becomes 1.
  - reg_write is ignored.
  - All rd lanes load 0.
- **RUN state:**
  - If reg_write=1 and wn!=0, entry[wn] takes wd at the clock edge.
  - A write with wn=0 is dropped.
- **Read port i (RUN):**
  - rd[i] loads entry[rn[i]] at each edge.
  - If rn[i]=0, rd[i] loads 0.
- **Duplicate addresses:** any number of ports may address the same register; each gets the same value.
- **Reset mid-sweep or mid-operation:** restarts CLEAR from pointer 1. Any write in flight is lost.

## Timing
- Read latency is 1 cycle: rn sampled at edge k appears on rd after edge k.
- Write latency is 1 cycle: a register written at edge k is readable by an rn presented in cycle k+1, giving data after edge k+1.
- Same-cycle write and read of the same register (reg_write=1, wn=rn[i]!=0): result depends on REGFILE_BYPASS_EN (see Configuration).
- The clear sweep takes DEPTH-1 cycles after rst_n deasserts. ready rises after edge DEPTH-1.
- No combinational path exists from inputs to outputs.

## Configuration
- **REGFILE_BYPASS_EN defined:** on a same-cycle address match (RUN state, reg_write=1, wn=rn[i], wn!=0), rd[i] loads wd. This is write-before-read.
- **REGFILE_BYPASS_EN undefined:** rd[i] loads the old entry value. This is read-before-write, and the pipeline forwarding unit must cover the hazard.
- In both cases register 0 never forwards.

## Structure
- **reg_file_pkg** holds:
  - default constants REGFILE_WIDTH=32, REGFILE_DEPTH=32, REGFILE_NREAD=2;
  - the FSM state typedef (CLEAR, RUN).
- **reg_file_rd_port** sub-module, instantiated NREAD times via generate. Each instance contains:
  - the read mux;
  - zero-register masking;
  - the optional bypass compare;
  - the rd output register.
- The top level holds the array, the write logic, the clear FSM and the pointer.

## Test plan
- **Reset sweep:** preload garbage by forcing the array, assert rst_n low for 3 cycles, then release.
  - ready=0 for exactly 31 cycles, then 1.
  - Reading all 32 registers then returns 0.
- **Basic write/read:** write 0xDEADBEEF to r5, next cycle read rn0=5, rn1=5.
  - Both rd lanes show 0xDEADBEEF one cycle later.
- **Register 0:** write 0x12345678 with wn=0, then read r0.
  - rd=0. The sweep must not have been disturbed.
- **Same-cycle hazard:** r7 holds 0x1, then write 0x2 to r7 while rn0=7.
  - rd0=0x2 with REGFILE_BYPASS_EN defined.
  - rd0=0x1 without it.
  - rd0=0x2 on the following read in both cases.
- **Writes during CLEAR:** assert reg_write with wn=3, wd=0xFF during the sweep.
  - After ready, r3 reads 0.
- **Reset mid-operation and parametrisation:**
  - Drop rst_n during a RUN write: rd goes to 0 immediately and the sweep restarts.
  - Repeat the write/read checks at WIDTH=16, DEPTH=8, NREAD=4 with distinct addresses on all four ports.
